// File: rtl/usb_uart_tx_fifo.sv
// usb_uart_tx_fifo
//   Byte FIFO plus a write-side sequencer that drains it into the usb_uart
//   write port. The client pushes bytes with a valid/ready handshake, at most
//   one per clock. Each byte is presented on uart_di with uart_we held high
//   until uart_wait is low. After every accepted write there is at least one
//   idle cycle. When CRLF=1, each LF byte is sent as CR and then LF.
//
// Ports
//   clk_48mhz     sole clock, rising edge
//   resetn        async active-low reset
//   in_valid      client byte valid
//   in_data[7:0]  client byte
//   in_ready      FIFO not full
//   level         bytes stored (0..2**DEPTH_LOG2)
//   overflow      sticky: push attempted while full
//   clr_overflow  synchronous clear of overflow (a same-cycle set wins)
//   busy          FIFO non-empty or a write is in progress
//   uart_we       write strobe to usb_uart
//   uart_di[7:0]  write data to usb_uart
//   uart_wait     usb_uart stall; a write completes when it is low
//
// Sequencer states
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | uart_we low; launches the head byte, or a CR before an LF
//   ST_SEND_CR | CR of an LF expansion on the bus; the LF stays in the FIFO
//   ST_SEND    | popped byte on the bus, waiting for uart_wait low

module usb_uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter bit CRLF       = 1'b1
) (
  input  logic                  clk_48mhz,
  input  logic                  resetn,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clr_overflow,
  output logic                  busy,
  output logic                  uart_we,
  output logic [7:0]            uart_di,
  input  logic                  uart_wait
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LP_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_CR = 2'd1,
    ST_SEND    = 2'd2
  } state_t;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_overflow;

  state_t                r_state;
  logic                  r_uart_we;
  logic [7:0]            r_uart_di;
  logic                  r_cr_done;

  state_t                w_state_nxt;
  logic                  w_we_nxt;
  logic [7:0]            w_di_nxt;
  logic                  w_cr_done_nxt;
  logic                  w_pop;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic [7:0]            w_head;

  // Full and empty come from the registered level, so in_ready never depends
  // on a pop happening in the same cycle.
  assign w_full   = (r_level == LP_FULL);
  assign w_empty  = (r_level == '0);
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_mem[r_rd_ptr];

  assign in_ready = !w_full;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign busy     = !w_empty || r_uart_we;
  assign uart_we  = r_uart_we;
  assign uart_di  = r_uart_di;

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk_48mhz) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk_48mhz or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_level <= r_level - (DEPTH_LOG2 + 1)'(1);
        default: r_level <= r_level;
      endcase
      if (in_valid && w_full) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_48mhz or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_uart_we <= 1'b0;
      r_uart_di <= 8'h00;
      r_cr_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_uart_we <= w_we_nxt;
      r_uart_di <= w_di_nxt;
      r_cr_done <= w_cr_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_we_nxt      = r_uart_we;
    w_di_nxt      = r_uart_di;
    w_cr_done_nxt = r_cr_done;
    w_pop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_we_nxt = 1'b0;
        if (!w_empty) begin
          // The LF stays at the head while its CR goes out. cr_done marks
          // that the CR has been sent, so the next visit pops the LF.
          if (CRLF && (w_head == 8'h0A) && !r_cr_done) begin
            w_di_nxt      = 8'h0D;
            w_we_nxt      = 1'b1;
            w_cr_done_nxt = 1'b1;
            w_state_nxt   = ST_SEND_CR;
          end else begin
            w_di_nxt      = w_head;
            w_we_nxt      = 1'b1;
            w_pop         = 1'b1;
            w_cr_done_nxt = 1'b0;
            w_state_nxt   = ST_SEND;
          end
        end
      end
      ST_SEND_CR, ST_SEND: begin
        if (!uart_wait) begin
          w_we_nxt    = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_we_nxt    = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
